instr_mem_pipe: RTL
===================

# instr_mem_pipe

Parametrised, pipelined instruction memory for the Sodor verification harness: the next generation of the single-cycle instruction ROM model. It accepts fetch requests over a req/gnt handshake and returns each instruction after a configurable latency through a response queue with ready backpressure, with a bounded number of outstanding requests. It also provides a side-band load port so the bench can write program contents at run time. It sits between the core's instruction fetch port and the bench's program loader.

## Interface
- ID, 0, instance identifier; distinguishes multiple memories in one bench, no functional effect
- DEPTH, 128, number of 32-bit words; power of two, 4..4096
- BASE_ADDR, 32'h0, byte address of word 0; 4-byte aligned
- LATENCY, 1, cycles from accept to earliest response; 1..4
- MAX_OUTSTANDING, 2, accepted requests not yet popped; 1..8
- NOP, 32'h00000013, word returned for disabled or out-of-range fetches
- clk_i  in  1  clock; all state changes on the rising edge
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  when low, accepted fetches return NOP
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  request accepted this cycle (combinational)
- instr_rvalid_o  out  1  response at queue head valid
- instr_rready_i  in  1  consumer takes response
- instr_o  out  32  response instruction
- instr_err_o  out  1  response error flag; present only with INSTR_MEM_ERR_EN
- load_we_i  in  1  load-port write enable
- load_addr_i  in  $clog2(DEPTH)  load-port word index
- load_data_i  in  32  load-port write data

## Operation
- Memory array is initialised to NOP at time zero. Reset does not alter it.
- Load port: when load_we_i is high, mem[load_addr_i] is written at the edge.
- Offset = instr_addr_i - BASE_ADDR, 32-bit unsigned; addresses below BASE_ADDR wrap to large values. Index = offset >> 2; in range iff offset < DEPTH*4.
- Accept: instr_gnt_o = instr_req_i && (outstanding < MAX_OUTSTANDING). The outstanding count is the registered count of accepted, unpopped requests.
- The response word is resolved at the accept edge: enable_i ? (in range ? mem[index] : NOP) : NOP. Bits [1:0] of the address are ignored for data.
- Read and load of the same index in the same cycle returns the old word.
- The resolved word goes through a LATENCY-1 register pipeline, then into a FIFO of MAX_OUTSTANDING entries. The FIFO cannot overflow because of the credit check.
- instr_rvalid_o = FIFO not empty; instr_o = FIFO head, or NOP when empty. A pop happens when instr_rvalid_o && instr_rready_i.
- Outstanding count: +1 on accept, -1 on pop; both in the same cycle leaves it unchanged. A pop does not free a grant in the same cycle, so there is no rready-to-gnt path.
- Responses return strictly in request order.
- Reset, including mid-operation: pipeline and FIFO are flushed, outstanding = 0, and in-flight responses are discarded.
- Reset values: instr_gnt_o follows its equation (0 while instr_req_i = 0), instr_rvalid_o = 0, instr_o = NOP, instr_err_o = 0.

## Timing
- A request accepted in cycle c has its response visible at the earliest in cycle c+LATENCY, if all older responses have been popped.
- Back-to-back acceptance with rready held high requires MAX_OUTSTANDING >= LATENCY+1. Otherwise gnt drops periodically.
- With rready low, the FIFO fills, outstanding reaches MAX_OUTSTANDING, and gnt stays low until the first pop, then reasserts the cycle after.

## Configuration
- INSTR_MEM_ERR_EN defined: instr_err_o exists and travels with each response. It is 1 when the accepted address was out of range or had addr[1:0] != 0. Out-of-range still returns NOP; misaligned returns mem[index].
- INSTR_MEM_ERR_EN undefined: there is no instr_err_o port and no error state; behaviour is otherwise identical.

## Test plan
- Reset, LATENCY=1: after rst_ni rises, fetch 0x0 -> rvalid the next cycle, instr_o = 32'h00000013.
- Load mem[3]=32'h00500093, LATENCY=3, MAX_OUTSTANDING=4, req 0x0C in cycle 10 -> gnt in cycle 10, rvalid with 32'h00500093 in cycle 13.
- Back-to-back requests to 0x0, 0x4, 0x8 with rready=1, LATENCY=2, MAX_OUTSTANDING=3 -> gnt every cycle, responses on three consecutive cycles in order.
- rready=0, MAX_OUTSTANDING=2: two accepts, then gnt=0 while req is held. Set rready=1 for one cycle -> one pop, gnt=1 the following cycle.
- BASE_ADDR=32'h80000000: fetch 0x7FFFFFFC and 0x80000000+DEPTH*4 -> both return NOP (instr_err_o=1 with macro). Fetch with enable_i=0 -> NOP.
- Reset asserted with 2 responses queued -> rvalid=0 and instr_o=NOP immediately; no stale responses after release.

Source files
------------

// File: rtl/instr_mem_pipe.sv
// Pipelined instruction memory: req/gnt fetch port, LATENCY-deep read pipeline, in-order response FIFO,
// credit-limited outstanding requests and a side-band load port. Optional error flag: INSTR_MEM_ERR_EN.
module instr_mem_pipe #(
  parameter int unsigned ID              = 0,
  parameter int unsigned DEPTH           = 128,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP             = 32'h00000013
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     instr_req_i,
  input  logic [31:0]              instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  input  logic                     instr_rready_i,
  output logic [31:0]              instr_o,
`ifdef INSTR_MEM_ERR_EN
  output logic                     instr_err_o,
`endif
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [31:0]              load_data_i
);

  localparam int AW = $clog2(DEPTH);
`ifdef INSTR_MEM_ERR_EN
  localparam int PW = 33;
`else
  localparam int PW = 32;
`endif
  localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  logic [31:0] w_unused_id;
  assign w_unused_id = ID;

  // Contents survive reset; only the declaration initialiser sets them to NOP.
  logic [31:0] r_mem [DEPTH] = '{default: NOP};

  always_ff @(posedge clk_i) begin
    if (load_we_i) r_mem[load_addr_i] <= load_data_i;
  end

  logic [31:0]   w_offset;
  logic          w_in_range;
  logic [AW-1:0] w_index;
  logic [31:0]   w_word;
  logic [PW-1:0] w_payload;

  assign w_offset   = instr_addr_i - BASE_ADDR;
  assign w_in_range = (w_offset < SPAN);
  assign w_index    = w_offset[AW+1:2];
  // Sampled before the load edge, so a same-cycle load to this index is not seen.
  assign w_word     = (enable_i && w_in_range) ? r_mem[w_index] : NOP;
`ifdef INSTR_MEM_ERR_EN
  assign w_payload  = {(!w_in_range || (instr_addr_i[1:0] != 2'b00)), w_word};
`else
  assign w_payload  = w_word;
`endif

  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_fifo_cnt;
  logic          w_pop;

  assign instr_gnt_o    = instr_req_i && (r_outstanding < CW'(MAX_OUTSTANDING));
  assign instr_rvalid_o = (r_fifo_cnt != '0);
  assign w_pop          = instr_rvalid_o && instr_rready_i;

  logic          w_push;
  logic [PW-1:0] w_push_data;

  generate
    if (LATENCY == 1) begin : g_direct
      assign w_push      = instr_gnt_o;
      assign w_push_data = w_payload;
    end else begin : g_pipe
      logic          r_pv [LATENCY-1];
      logic [PW-1:0] r_pd [LATENCY-1];
      genvar gi;
      for (gi = 0; gi < LATENCY - 1; gi++) begin : g_stage
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            r_pv[gi] <= 1'b0;
            r_pd[gi] <= '0;
          end else if (gi == 0) begin
            r_pv[gi] <= instr_gnt_o;
            r_pd[gi] <= w_payload;
          end else begin
            r_pv[gi] <= r_pv[(gi == 0) ? 0 : gi - 1];
            r_pd[gi] <= r_pd[(gi == 0) ? 0 : gi - 1];
          end
        end
      end
      assign w_push      = r_pv[LATENCY-2];
      assign w_push_data = r_pd[LATENCY-2];
    end
  endgenerate

  // The credit check on gnt guarantees a free slot for every push.
  logic [PW-1:0] r_fifo [MAX_OUTSTANDING];
  logic [FW-1:0] r_wr_ptr;
  logic [FW-1:0] r_rd_ptr;
  logic [FW-1:0] w_wr_ptr_next;
  logic [FW-1:0] w_rd_ptr_next;

  assign w_wr_ptr_next = (r_wr_ptr == FW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + FW'(1);
  assign w_rd_ptr_next = (r_rd_ptr == FW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + FW'(1);

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_fifo_cnt    <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_next;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_next;
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      case ({instr_gnt_o, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  logic [PW-1:0] w_head;
  assign w_head  = r_fifo[r_rd_ptr];
  assign instr_o = instr_rvalid_o ? w_head[31:0] : NOP;
`ifdef INSTR_MEM_ERR_EN
  assign instr_err_o = instr_rvalid_o && w_head[32];
`endif

endmodule
